// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out byte transmitter.
// Frame on q: start bit (0), 8 data bits LSB first, optional even-parity bit,
// stop bit (1). Every bit is held for CLKS_PER_BIT clocks by a down-counting
// bit timer that advances the state when it reaches zero. All outputs are
// registered, so there is no combinational path from din/load to q.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle high; ready=1 from the first edge after reset
// S_START  | start bit (q=0)
// S_DATA   | data bits, q = shift-register LSB, bit_idx counts 0..7
// S_PARITY | even parity over the captured byte (only when PARITY_EN!=0)
// S_STOP   | stop bit (q=1); expiry returns to S_IDLE for at least 1 cycle

module piso_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       q,
    output logic       qn
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Reload value makes each bit last exactly CLKS_PER_BIT cycles; with
    // CLKS_PER_BIT=1 it is zero, so every bit expires on its first cycle and
    // the timer is never decremented below zero.
    localparam logic [15:0] TMR_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam bit          HAS_PARITY = (PARITY_EN != 0);

    state_t      state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bit;

    // Frame sequencer: state, bit timer, shifter and registered line outputs.
    // q and qn are always written together so qn stays the complement of q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            q       <= 1'b1;
            qn      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // ready is registered: it rises on the first edge after
                    // reset, so a load can only be taken from the second edge.
                    if (ready && load) begin
                        shreg   <= din;
                        par_bit <= ^din;
                        timer   <= TMR_RELOAD;
                        bit_idx <= '0;
                        state   <= S_START;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        q       <= 1'b0;
                        qn      <= 1'b1;
                    end else begin
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        q       <= 1'b1;
                        qn      <= 1'b0;
                    end
                end

                S_START: begin
                    if (timer == 16'd0) begin
                        timer   <= TMR_RELOAD;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        q       <= shreg[0];
                        qn      <= ~shreg[0];
                    end else begin
                        timer   <= timer - 16'd1;
                    end
                end

                S_DATA: begin
                    if (timer == 16'd0) begin
                        timer <= TMR_RELOAD;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                state <= S_PARITY;
                                q     <= par_bit;
                                qn    <= ~par_bit;
                            end else begin
                                state <= S_STOP;
                                q     <= 1'b1;
                                qn    <= 1'b0;
                            end
                        end else begin
                            // Shift first, so the next bit driven on q is
                            // the new LSB of the register.
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            q       <= shreg[1];
                            qn      <= ~shreg[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_PARITY: begin
                    if (timer == 16'd0) begin
                        timer <= TMR_RELOAD;
                        state <= S_STOP;
                        q     <= 1'b1;
                        qn    <= 1'b0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_STOP: begin
                    if (timer == 16'd0) begin
                        // Land in IDLE with ready already high: the next frame
                        // can start after exactly one idle-high cycle.
                        state <= S_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        q     <= 1'b1;
                        qn    <= 1'b0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    q     <= 1'b1;
                    qn    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx. Three lanes with different parameters:
//   lane0: CLKS_PER_BIT=4, parity on   (11-bit frames, 44 cycles)
//   lane1: CLKS_PER_BIT=4, parity off  (10-bit frames, 40 cycles)
//   lane2: CLKS_PER_BIT=1, parity on   (11-bit frames, 11 cycles)
// Frames are stored in transmit order: bit0 = start, bits1..8 = data LSB
// first, bit9 = parity (or stop without parity), bit10 = stop.

module tb_piso_tx;

    typedef logic [10:0] frame_t;

    // Hand-computed frames {stop, parity, data, start}.
    localparam frame_t F_A5   = 11'b1_0_10100101_0;  // popcount 4 -> parity 0
    localparam frame_t F_07   = 11'b1_1_00000111_0;  // popcount 3 -> parity 1
    localparam frame_t F_3C   = 11'b1_0_00111100_0;  // popcount 4 -> parity 0
    localparam frame_t F_5A   = 11'b1_0_01011010_0;  // popcount 4 -> parity 0
    localparam frame_t F_01NP = 11'b0_1_00000001_0;  // no parity: 10 bits

    logic       clk;
    logic       rst_n;
    logic [2:0] load_s;
    logic [7:0] din_s [3];
    wire  [2:0] ready_s, busy_s, q_s, qn_s;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    frame_t exp_q [3][$];
    int     frames_seen [3];
    int     aborted     [3];
    int     start_last  [3];
    int     start_prev  [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CPB = (g == 2) ? 1 : 4;
        localparam int PAR = (g == 1) ? 0 : 1;
        localparam int NS  = ((PAR != 0) ? 11 : 10) * CPB;

        piso_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PAR)) dut (
            .clk   (clk),
            .rst   (rst_n),
            .din   (din_s[g]),
            .load  (load_s[g]),
            .ready (ready_s[g]),
            .busy  (busy_s[g]),
            .q     (q_s[g]),
            .qn    (qn_s[g])
        );

        // Monitor: detects a start bit, pops the expected frame and compares
        // the full sampled waveform, busy/ready/qn during the frame and the
        // idle cycle that must follow it.
        initial begin : mon
            logic [63:0] aw, ew;
            logic        pq, ball, rany, qnok, abort;
            frame_t      f;
            pq = 1'b1;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && q_s[g] === 1'b0 && pq === 1'b1) begin
                    chk($sformatf("lane%0d_frame_expected", g), 64'(exp_q[g].size() != 0), 64'd1);
                    if (exp_q[g].size() != 0) f = exp_q[g].pop_front();
                    else f = '0;
                    start_prev[g] = start_last[g];
                    start_last[g] = cyc;
                    aw = '0; ew = '0; ball = 1'b1; rany = 1'b0; qnok = 1'b1; abort = 1'b0;
                    for (int i = 0; i < NS; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                        aw[i] = q_s[g];
                        ew[i] = f[i / CPB];
                        ball  = ball & busy_s[g];
                        rany  = rany | ready_s[g];
                        qnok  = qnok & (qn_s[g] === ~q_s[g]);
                    end
                    if (abort) begin
                        aborted[g]++;
                        pq = 1'b1;
                    end else begin
                        chk($sformatf("lane%0d_frame_wave", g), aw, ew);
                        chk($sformatf("lane%0d_busy_in_frame", g), 64'(ball), 64'd1);
                        chk($sformatf("lane%0d_ready_in_frame", g), 64'(rany), 64'd0);
                        chk($sformatf("lane%0d_qn_in_frame", g), 64'(qnok), 64'd1);
                        @(negedge clk);
                        chk($sformatf("lane%0d_idle_after_stop{q,qn,busy,ready}", g),
                            64'({q_s[g], qn_s[g], busy_s[g], ready_s[g]}), 64'b1001);
                        frames_seen[g]++;
                        pq = q_s[g];
                    end
                end else begin
                    pq = q_s[g];
                end
            end
        end
    end

    task automatic send(input int l, input logic [7:0] d, input frame_t f, input bit keep);
        int k = 0;
        while (ready_s[l] !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("lane%0d_ready_wait", l), 64'(ready_s[l]), 64'd1);
        din_s[l]  = d;
        load_s[l] = 1'b1;
        exp_q[l].push_back(f);
        @(negedge clk);
        if (!keep) load_s[l] = 1'b0;
    endtask

    task automatic wait_frames(input int l, input int n);
        int k = 0;
        while (frames_seen[l] < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("lane%0d_frames_reached_%0d", l, n), 64'(frames_seen[l] >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst_n  = 1'b0;
        load_s = '0;
        for (int i = 0; i < 3; i++) begin
            din_s[i]       = 8'h00;
            frames_seen[i] = 0;
            aborted[i]     = 0;
            start_last[i]  = 0;
            start_prev[i]  = 0;
        end

        // Reset values on every lane.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("lane%0d_reset{q,qn,ready,busy}", i),
                64'({q_s[i], qn_s[i], ready_s[i], busy_s[i]}), 64'b1000);

        // Release with load already high: first edge only raises ready,
        // second edge accepts (lane1, parity disabled, 8'h01).
        rst_n     = 1'b1;
        load_s[1] = 1'b1;
        din_s[1]  = 8'h01;
        exp_q[1].push_back(F_01NP);
        #1 chk("lane1_ready_before_first_edge", 64'(ready_s[1]), 64'd0);
        @(negedge clk);
        chk("lane1_first_edge{ready,q}", 64'({ready_s[1], q_s[1]}), 64'b11);
        @(negedge clk);
        chk("lane1_second_edge{q,busy,ready}", 64'({q_s[1], busy_s[1], ready_s[1]}), 64'b010);
        load_s[1] = 1'b0;
        wait_frames(1, 1);

        // Single frames with parity: 8'hA5 (lane0) and 8'h07 at one clock per bit (lane2).
        send(0, 8'hA5, F_A5, 1'b0);
        send(2, 8'h07, F_07, 1'b0);
        wait_frames(0, 1);
        wait_frames(2, 1);

        // Load with 8'hFF around cycle 10 of an 8'hA5 frame must be ignored.
        send(0, 8'hA5, F_A5, 1'b0);
        repeat (9) @(negedge clk);
        din_s[0]  = 8'hFF;
        load_s[0] = 1'b1;
        @(negedge clk);
        load_s[0] = 1'b0;
        wait_frames(0, 2);
        repeat (60) @(negedge clk);
        chk("lane0_no_ff_frame_count", 64'(frames_seen[0]), 64'd2);
        chk("lane0_no_ff_queue_empty", 64'(exp_q[0].size()), 64'd0);

        // Back-to-back with load held high.
        send(0, 8'h07, F_07, 1'b1);
        send(0, 8'h3C, F_3C, 1'b0);
        wait_frames(0, 4);
        chk("lane0_b2b_start_spacing", 64'(start_last[0] - start_prev[0]), 64'd45);
        send(2, 8'h07, F_07, 1'b1);
        send(2, 8'h07, F_07, 1'b1);
        send(2, 8'h07, F_07, 1'b0);
        wait_frames(2, 4);
        chk("lane2_b2b_start_spacing", 64'(start_last[2] - start_prev[2]), 64'd12);

        // Asynchronous reset during DATA bit 3 of an 8'h5A frame.
        send(0, 8'h5A, F_5A, 1'b0);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("lane0_async_reset{q,qn,busy,ready}",
               64'({q_s[0], qn_s[0], busy_s[0], ready_s[0]}), 64'b1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b1;
        repeat (5) begin
            @(negedge clk);
            acc = acc & q_s[0] & ~qn_s[0] & ~busy_s[0];
        end
        chk("lane0_no_resume_after_reset", 64'(acc), 64'd1);
        send(0, 8'h3C, F_3C, 1'b0);
        wait_frames(0, 5);
        chk("lane0_aborted_frames", 64'(aborted[0]), 64'd1);

        // Final bookkeeping.
        repeat (5) @(negedge clk);
        chk("lane0_total_frames", 64'(frames_seen[0]), 64'd5);
        chk("lane1_total_frames", 64'(frames_seen[1]), 64'd1);
        chk("lane2_total_frames", 64'(frames_seen[2]), 64'd4);
        for (int i = 0; i < 3; i++)
            chk($sformatf("lane%0d_queue_drained", i), 64'(exp_q[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
